pulse_scheduler: RTL and testbench

Sequencing controller that shares a single pulse-train output between two requesters. On a granted request it emits a programmed number of pulses with programmable high and low lengths on `signal`, then reports completion with a one-cycle `done` strobe. It sits between the test-bench stimulus or control logic and any consumer of pulse/trigger waveforms. It replaces free-running pulse and trigger generators with an arbitrated, counted, abortable source.

---
 rtl/pulse_scheduler.sv | 153 +++++++++++++++
 tb/tb_pulse_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_scheduler.sv
// Arbitrated pulse-train source: two requesters share one counted, abortable
// output with programmable high/low phase lengths and a completion strobe.
module pulse_scheduler #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         on,
    input  logic [1:0]   req,
    input  logic [3:0]   cnt0,
    input  logic [3:0]   cnt1,
    input  logic [W-1:0] high_len,
    input  logic [W-1:0] low_len,
    output logic         signal,
    output logic [1:0]   grant,
    output logic         busy,
    output logic [1:0]   done,
    output logic         aborted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [3:0]   r_rem;
    logic [W-1:0] r_phase;
    logic [W-1:0] r_high_m1;
    logic [W-1:0] r_low_m1;
    logic         r_owner;
    logic         r_last;
    logic         r_signal;
    logic [1:0]   r_grant;
    logic         r_busy;
    logic [1:0]   r_done;
    logic         r_aborted;

    logic         w_start;
    logic         w_winner;
    logic [3:0]   w_win_cnt;
    logic [W-1:0] w_high_m1;
    logic [W-1:0] w_low_m1;
    logic         w_phase_end;
    logic [3:0]   w_rem_dec;
    logic         w_abort;
    logic         w_owner_next;
    logic         w_signal_next;
    logic [1:0]   w_grant_next;
    logic         w_busy_next;
    logic [1:0]   w_done_next;
    logic         w_aborted_next;

    // Round-robin: a lone requester wins; with both, the one not served last.
    assign w_start     = (r_state == S_IDLE) && on && (req != 2'b00);
    assign w_winner    = (req == 2'b11) ? ~r_last : req[1];
    assign w_win_cnt   = w_winner ? cnt1 : cnt0;
    assign w_high_m1   = (high_len == '0) ? '0 : high_len - W'(1);
    assign w_low_m1    = (low_len == '0) ? '0 : low_len - W'(1);
    assign w_phase_end = (r_phase == '0);
    assign w_rem_dec   = r_rem - 4'd1;
    assign w_abort     = ((r_state == S_HIGH) || (r_state == S_LOW)) && !on;

    // State register plus latched sequence parameters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rem     <= 4'd0;
            r_phase   <= '0;
            r_high_m1 <= '0;
            r_low_m1  <= '0;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_signal  <= 1'b0;
            r_grant   <= 2'b00;
            r_busy    <= 1'b0;
            r_done    <= 2'b00;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_owner   <= w_owner_next;
            r_signal  <= w_signal_next;
            r_grant   <= w_grant_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_aborted <= w_aborted_next;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_rem     <= w_win_cnt;
                        r_high_m1 <= w_high_m1;
                        r_low_m1  <= w_low_m1;
                        r_phase   <= w_high_m1;
                    end
                end
                S_HIGH: begin
                    if (w_phase_end) begin
                        r_rem   <= w_rem_dec;
                        r_phase <= r_low_m1;
                    end else begin
                        r_phase <= r_phase - W'(1);
                    end
                end
                S_LOW: begin
                    r_phase <= w_phase_end ? r_high_m1 : r_phase - W'(1);
                end
                S_DONE: begin
                    r_last <= r_owner;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_next = (w_win_cnt != 4'd0) ? S_HIGH : S_DONE;
            end
            S_HIGH: begin
                if (w_abort)          w_state_next = S_DONE;
                else if (w_phase_end) w_state_next = (w_rem_dec == 4'd0) ? S_DONE : S_LOW;
            end
            S_LOW: begin
                if (w_abort)          w_state_next = S_DONE;
                else if (w_phase_end) w_state_next = S_HIGH;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are valid right after the edge.
    always_comb begin
        w_owner_next   = w_start ? w_winner : r_owner;
        w_signal_next  = (w_state_next == S_HIGH);
        w_busy_next    = (w_state_next != S_IDLE);
        w_grant_next   = w_busy_next ? {w_owner_next, ~w_owner_next} : 2'b00;
        w_done_next    = (w_state_next == S_DONE) ? {w_owner_next, ~w_owner_next} : 2'b00;
        w_aborted_next = w_abort;
    end

    assign signal  = r_signal;
    assign grant   = r_grant;
    assign busy    = r_busy;
    assign done    = r_done;
    assign aborted = r_aborted;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler: expected per-cycle outputs are queued
// as stimulus is set up, then popped and compared after each clock edge.
module tb_pulse_scheduler;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         on;
    logic [1:0]   req;
    logic [3:0]   cnt0;
    logic [3:0]   cnt1;
    logic [W-1:0] high_len;
    logic [W-1:0] low_len;
    logic         signal;
    logic [1:0]   grant;
    logic         busy;
    logic [1:0]   done;
    logic         aborted;

    typedef struct {
        logic [6:0] val;   // {signal, grant, busy, done, aborted}
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    pulse_scheduler #(.W(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .on       (on),
        .req      (req),
        .cnt0     (cnt0),
        .cnt1     (cnt1),
        .high_len (high_len),
        .low_len  (low_len),
        .signal   (signal),
        .grant    (grant),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic push(input logic s, input logic [1:0] g, input logic b,
                        input logic [1:0] d, input logic a, input string tag);
        exp_t e;
        e.val = {s, g, b, d, a};
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic idle(input string tag);
        push(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, tag);
    endtask

    // Advance n cycles, checking each post-edge output against the queue head.
    task automatic run(input int n);
        exp_t       e;
        logic [6:0] obs;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            obs = {signal, grant, busy, done, aborted};
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: observed %b expected <queued entry>", obs);
            end else begin
                e = sb.pop_front();
                assert (obs === e.val) else begin
                    n_bad++;
                    $error("FAIL %s: observed sig/gnt/bsy/dn/ab=%b expected %b", e.tag, obs, e.val);
                end
                $display("cycle %s: sig/gnt/bsy/dn/ab=%b", e.tag, obs);
            end
        end
    endtask

    initial begin
        reset = 1'b1; on = 1'b0; req = 2'b00; cnt0 = 4'd0; cnt1 = 4'd0;
        high_len = '0; low_len = '0;

        // Reset state
        idle("reset0"); idle("reset1");
        run(2);

        // Single requester: cnt0=3, H=2, L=1
        reset = 1'b0; on = 1'b1; req = 2'b01; cnt0 = 4'd3; high_len = 8'd2; low_len = 8'd1;
        push(1, 2'b01, 1, 2'b00, 0, "single_h0");
        push(1, 2'b01, 1, 2'b00, 0, "single_h1");
        push(0, 2'b01, 1, 2'b00, 0, "single_l2");
        push(1, 2'b01, 1, 2'b00, 0, "single_h3");
        push(1, 2'b01, 1, 2'b00, 0, "single_h4");
        push(0, 2'b01, 1, 2'b00, 0, "single_l5");
        push(1, 2'b01, 1, 2'b00, 0, "single_h6");
        push(1, 2'b01, 1, 2'b00, 0, "single_h7");
        push(0, 2'b01, 1, 2'b01, 0, "single_done");
        idle("single_idle");
        run(1);
        req = 2'b00; cnt0 = 4'd9; high_len = 8'd7;   // ignored mid-sequence
        run(9);

        // Contention after reset: grants 01, 10, 01
        reset = 1'b1;
        idle("cont_reset");
        run(1);
        reset = 1'b0; req = 2'b11; cnt0 = 4'd1; cnt1 = 4'd1; high_len = 8'd1; low_len = 8'd1;
        push(1, 2'b01, 1, 2'b00, 0, "cont_g0");
        push(0, 2'b01, 1, 2'b01, 0, "cont_d0");
        idle("cont_i0");
        push(1, 2'b10, 1, 2'b00, 0, "cont_g1");
        push(0, 2'b10, 1, 2'b10, 0, "cont_d1");
        idle("cont_i1");
        push(1, 2'b01, 1, 2'b00, 0, "cont_g2");
        push(0, 2'b01, 1, 2'b01, 0, "cont_d2");
        run(8);
        req = 2'b00;
        idle("cont_i2");
        run(1);

        // Zero count on requester 1
        req = 2'b10; cnt1 = 4'd0;
        push(0, 2'b10, 1, 2'b10, 0, "zcnt_done");
        idle("zcnt_idle");
        run(1);
        req = 2'b00;
        run(1);

        // Zero lengths behave as one cycle
        req = 2'b01; cnt0 = 4'd2; high_len = 8'd0; low_len = 8'd0;
        push(1, 2'b01, 1, 2'b00, 0, "zlen_h0");
        push(0, 2'b01, 1, 2'b00, 0, "zlen_l1");
        push(1, 2'b01, 1, 2'b00, 0, "zlen_h2");
        push(0, 2'b01, 1, 2'b01, 0, "zlen_done");
        idle("zlen_idle");
        run(1);
        req = 2'b00;
        run(4);

        // Abort during LOW of a 3-pulse sequence
        req = 2'b01; cnt0 = 4'd3; high_len = 8'd2; low_len = 8'd2;
        push(1, 2'b01, 1, 2'b00, 0, "abort_h0");
        push(1, 2'b01, 1, 2'b00, 0, "abort_h1");
        push(0, 2'b01, 1, 2'b00, 0, "abort_l2");
        push(0, 2'b01, 1, 2'b01, 1, "abort_done");
        idle("abort_i0"); idle("abort_i1"); idle("abort_i2");
        run(1);
        req = 2'b00;
        run(2);
        on = 1'b0;
        run(1);
        req = 2'b11;
        run(3);

        // Reset mid-HIGH, then requester 0 must win contention
        on = 1'b1; req = 2'b01; cnt0 = 4'd3; high_len = 8'd4; low_len = 8'd1;
        push(1, 2'b01, 1, 2'b00, 0, "rst_h0");
        push(1, 2'b01, 1, 2'b00, 0, "rst_h1");
        idle("rst_cleared");
        run(1);
        req = 2'b00;
        run(1);
        reset = 1'b1;
        run(1);
        reset = 1'b0; req = 2'b11; cnt0 = 4'd1; cnt1 = 4'd1; high_len = 8'd1;
        push(1, 2'b01, 1, 2'b00, 0, "rst_g0");
        push(0, 2'b01, 1, 2'b01, 0, "rst_d0");
        idle("rst_idle");
        run(1);
        req = 2'b00;
        run(2);

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: observed %0d entries expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
